// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the MEM stage (load/store).
// Latency: request sampled at edge 0, memory access from edge 1, ready pulse in cycle 2, plus one cycle per mf_stall cycle.
// Backpressure: one transaction in flight, held while mf_stall=1; losing requesters see stall until their ready pulse.
module mem_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              mf_v,
  output logic              mf_we,
  output logic [ADDR_W-1:0] mf_address,
  output logic [DATA_W-1:0] mf_data,
  input  logic              mf_stall,
  input  logic [DATA_W-1:0] mf_data_out
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          grant_if;
  logic          pick_if;

  // IF wins when it is alone, or when MEM has starved it STARVE_MAX times in a row
  always_comb begin
    pick_if = if_req & (~mem_req | (starve_cnt == STARVE_LIM));
  end

  // Stalls are held low during reset so every output reads 0 while reset is asserted
  assign if_stall  = ~reset & if_req  & ~if_ready;
  assign mem_stall = ~reset & mem_req & ~mem_ready;

  // Arbitration FSM with registered memory-side and response outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      grant_if   <= 1'b0;
      mf_v       <= 1'b0;
      mf_we      <= 1'b0;
      mf_address <= '0;
      mf_data    <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | mem_req) begin
            grant_if <= pick_if;
            mf_v     <= 1'b1;
            state    <= BUSY;
            if (pick_if) begin
              mf_we      <= 1'b0;
              mf_address <= if_addr;
              mf_data    <= '0;
            end else begin
              mf_we      <= mem_we;
              mf_address <= mem_addr;
              mf_data    <= mem_wdata;
            end
            // Count only MEM grants that left a fetch waiting
            if (pick_if | ~if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        BUSY: begin
          if (!mf_stall) begin
            mf_v  <= 1'b0;
            mf_we <= 1'b0;
            state <= RESP;
            if (grant_if) begin
              if_rdata <= mf_data_out;
              if_ready <= 1'b1;
            end else begin
              // Stores leave the last load data in place
              if (!mf_we) begin
                mem_rdata <= mf_data_out;
              end
              mem_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store/load with stall,
// starvation ordering, reset abort and dropped request.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        mf_v;
  logic        mf_we;
  logic [63:0] mf_address;
  logic [63:0] mf_data;
  logic        mf_stall;
  logic [63:0] mf_data_out;

  int checks = 0;
  int errors = 0;

  logic got_if, got_mem, exp_if;

  mem_port_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_MAX(4)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .if_stall   (if_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_stall  (mem_stall),
    .mf_v       (mf_v),
    .mf_we      (mf_we),
    .mf_address (mf_address),
    .mf_data    (mf_data),
    .mf_stall   (mf_stall),
    .mf_data_out(mf_data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mf_v"},       mf_v,       0);
    check({tag, "_mf_we"},      mf_we,      0);
    check({tag, "_mf_address"}, mf_address, 0);
    check({tag, "_mf_data"},    mf_data,    0);
    check({tag, "_if_rdata"},   if_rdata,   0);
    check({tag, "_mem_rdata"},  mem_rdata,  0);
    check({tag, "_if_ready"},   if_ready,   0);
    check({tag, "_mem_ready"},  mem_ready,  0);
    check({tag, "_if_stall"},   if_stall,   0);
    check({tag, "_mem_stall"},  mem_stall,  0);
  endtask

  // Advance to the next falling edge with a ready pulse, bounded to 20 cycles
  task automatic wait_ready(output logic gi, output logic gm);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (n < 20 && !(if_ready || mem_ready));
    check("wait_ready_timeout", (if_ready || mem_ready), 1);
    gi = if_ready;
    gm = mem_ready;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
    if_addr = 64'h8; mem_addr = 64'h18; mem_wdata = 64'h1234;
    mf_stall = 1'b0; mf_data_out = 64'hdead;

    // 1. Reset with both requests asserted
    @(negedge CLK); check_all_zero("rst_c0");
    @(negedge CLK); check_all_zero("rst_c1");
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; reset = 1'b0;
    @(negedge CLK);
    check("idle_mf_v", mf_v, 0);
    check("idle_if_ready", if_ready, 0);
    check("idle_mem_ready", mem_ready, 0);

    // 2. Single fetch
    if_addr = 64'h10; mf_data_out = 64'h43; if_req = 1'b1;
    #1 check("t2_if_stall_req", if_stall, 1);
    @(negedge CLK);
    check("t2_mf_v", mf_v, 1);
    check("t2_mf_address", mf_address, 64'h10);
    check("t2_mf_we", mf_we, 0);
    check("t2_if_ready_early", if_ready, 0);
    check("t2_if_stall_busy", if_stall, 1);
    @(negedge CLK);
    check("t2_mf_v_resp", mf_v, 0);
    check("t2_if_ready", if_ready, 1);
    check("t2_if_rdata", if_rdata, 64'h43);
    check("t2_if_stall_resp", if_stall, 0);
    if_req = 1'b0;
    @(negedge CLK);
    check("t2_if_ready_once", if_ready, 0);

    // 3a. Store of 67 to address 0 with three stall cycles
    mem_we = 1'b1; mem_addr = 64'h0; mem_wdata = 64'd67; mf_data_out = 64'h99;
    mf_stall = 1'b1; mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check($sformatf("t3_st_mf_v_%0d", c), mf_v, 1);
      check($sformatf("t3_st_mf_we_%0d", c), mf_we, 1);
      check($sformatf("t3_st_mf_data_%0d", c), mf_data, 64'd67);
      check($sformatf("t3_st_mem_ready_%0d", c), mem_ready, 0);
      check($sformatf("t3_st_mem_stall_%0d", c), mem_stall, 1);
      mem_wdata = 64'd1;
      if (c == 3) mf_stall = 1'b0;
    end
    @(negedge CLK);
    check("t3_st_mem_ready", mem_ready, 1);
    check("t3_st_mf_v_off", mf_v, 0);
    check("t3_st_mf_we_off", mf_we, 0);
    check("t3_st_mem_rdata_kept", mem_rdata, 0);
    mem_req = 1'b0;
    @(negedge CLK);
    check("t3_st_mem_ready_once", mem_ready, 0);

    // 3b. Load back from address 0
    mem_we = 1'b0; mem_addr = 64'h0; mf_data_out = 64'd67; mem_req = 1'b1;
    @(negedge CLK);
    check("t3_ld_mf_v", mf_v, 1);
    check("t3_ld_mf_we", mf_we, 0);
    check("t3_ld_mf_address", mf_address, 0);
    @(negedge CLK);
    check("t3_ld_mem_ready", mem_ready, 1);
    check("t3_ld_mem_rdata", mem_rdata, 64'd67);
    mem_req = 1'b0;
    @(negedge CLK);
    check("t3_ld_mem_ready_once", mem_ready, 0);

    // 4. Continuous contention: every fifth grant goes to IF
    if_addr = 64'h100; mem_addr = 64'h200; mem_we = 1'b0; mf_data_out = 64'h5a;
    if_req = 1'b1; mem_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      wait_ready(got_if, got_mem);
      exp_if = (t % 5 == 4);
      check($sformatf("t4_grant_if_%0d", t), got_if, exp_if);
      check($sformatf("t4_grant_mem_%0d", t), got_mem, !exp_if);
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge CLK);
    check("t4_if_ready_end", if_ready, 0);
    check("t4_mem_ready_end", mem_ready, 0);

    // 5. Reset while a stalled store is in flight
    mem_we = 1'b1; mem_addr = 64'h300; mem_wdata = 64'h5; mf_stall = 1'b1; mem_req = 1'b1;
    @(negedge CLK);
    check("t5_mf_v_busy", mf_v, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_mf_v_async", mf_v, 0);
    check("t5_mf_we_async", mf_we, 0);
    check("t5_mem_ready_async", mem_ready, 0);
    check("t5_mem_stall_async", mem_stall, 0);
    mem_req = 1'b0;
    @(negedge CLK);
    check("t5_mf_v_rst", mf_v, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("t5_mf_v_post_%0d", c), mf_v, 0);
      check($sformatf("t5_mem_ready_post_%0d", c), mem_ready, 0);
      check($sformatf("t5_if_ready_post_%0d", c), if_ready, 0);
    end
    mem_we = 1'b0; if_addr = 64'h20; mf_stall = 1'b0; mf_data_out = 64'h77; if_req = 1'b1;
    @(negedge CLK);
    check("t5_fetch_mf_v", mf_v, 1);
    check("t5_fetch_mf_address", mf_address, 64'h20);
    wait_ready(got_if, got_mem);
    check("t5_fetch_ready", got_if, 1);
    check("t5_fetch_rdata", if_rdata, 64'h77);
    if_req = 1'b0;
    @(negedge CLK);

    // 6. MEM drops its request mid-transaction while IF waits
    mem_we = 1'b0; mem_addr = 64'h400; if_addr = 64'h30; mf_stall = 1'b1; mf_data_out = 64'h55;
    mem_req = 1'b1; if_req = 1'b1;
    @(negedge CLK);
    check("t6_mem_granted", mf_address, 64'h400);
    mem_req = 1'b0;
    @(negedge CLK);
    check("t6_still_busy", mf_v, 1);
    mf_stall = 1'b0;
    @(negedge CLK);
    check("t6_mem_ready", mem_ready, 1);
    check("t6_mem_rdata", mem_rdata, 64'h55);
    check("t6_if_ready_none", if_ready, 0);
    check("t6_if_stall", if_stall, 1);
    mf_data_out = 64'h66;
    @(negedge CLK);
    check("t6_mem_ready_once", mem_ready, 0);
    check("t6_mf_v_idle", mf_v, 0);
    @(negedge CLK);
    check("t6_if_granted_v", mf_v, 1);
    check("t6_if_granted_addr", mf_address, 64'h30);
    check("t6_if_granted_we", mf_we, 0);
    wait_ready(got_if, got_mem);
    check("t6_if_ready", got_if, 1);
    check("t6_if_not_mem", got_mem, 0);
    check("t6_if_rdata", if_rdata, 64'h66);
    if_req = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memoryFile port between the instruction-fetch stage (read-only) and the MEM stage (load/store).
- Latches one request at a time and drives the memory-side valid, write-enable, address and data.
- Waits out the memory stall, then returns read data with a one-cycle ready pulse and a stall signal to each requester.
- MEM has fixed priority over IF. A starvation counter periodically forces an IF grant.

Parameters:
- DATA_W, 64, data width of all data buses
- ADDR_W, 64, address width
- STARVE_MAX, 4, consecutive MEM grants with IF waiting before IF is forced a grant (must be >=1)

Ports:
- CLK  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch read request; held until if_ready
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetch read data, valid when if_ready=1
- if_ready  output  1  one-cycle completion pulse for fetch
- if_stall  output  1  fetch must stall
- mem_req  input  1  load/store request; held until mem_ready
- mem_we  input  1  1=store, 0=load
- mem_addr  input  ADDR_W  load/store address
- mem_wdata  input  DATA_W  store data
- mem_rdata  output  DATA_W  load data, valid when mem_ready=1
- mem_ready  output  1  one-cycle completion pulse for MEM
- mem_stall  output  1  MEM stage must stall
- mf_v  output  1  memory transaction valid (to memoryFile MEM_V)
- mf_we  output  1  memory write enable
- mf_address  output  ADDR_W  memory address
- mf_data  output  DATA_W  memory write data
- mf_stall  input  1  memory busy (from v_mem_stall)
- mf_data_out  input  DATA_W  memory read data

Behaviour:
- Single clock CLK; reset asynchronous active-high.
- Reset values:
  - state=IDLE; starve_cnt=0
  - all outputs 0, including mf_v, mf_we, mf_address, mf_data, both rdata, both ready pulses and both stalls.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Arbitration at the clock edge with any req=1:
    - Only one requester active: grant it.
    - Both active and starve_cnt<STARVE_MAX: grant MEM.
    - Both active and starve_cnt==STARVE_MAX: grant IF.
  - On grant, register grant id, addr, we (forced 0 for IF) and wdata into mf_* outputs; go to BUSY.
- BUSY:
  - mf_v=1; mf_we, mf_address and mf_data are held stable from registers.
  - A transaction completes at the rising edge where mf_v=1 and mf_stall=0.
  - On completion, capture mf_data_out into the granted requester's rdata register. Loads and fetches only; stores leave mem_rdata unchanged.
  - Then go to RESP. mf_v and mf_we return to 0 in RESP.
  - mf_stall=1 keeps the arbiter in BUSY indefinitely. There is no timeout.
- RESP:
  - Granted requester's ready=1 for exactly one cycle, then return to IDLE.
  - No back-to-back issue: a new grant is taken at the IDLE edge.
- Latency: request sampled at edge 0, memory access at edge 1 (no stall), ready high cycle 2. Minimum 3 cycles per transaction, plus one per stall cycle.
- Stall outputs are combinational:
  - if_stall = if_req & ~if_ready
  - mem_stall = mem_req & ~mem_ready
- starve_cnt (width clog2(STARVE_MAX+1)) updates at each grant:
  - MEM grant with if_req=1: increment, saturating at STARVE_MAX.
  - IF grant, or MEM grant with if_req=0: clear to 0.
- A requester dropping req during BUSY does not abort. The transaction completes and ready still pulses; the stale ready is ignored upstream.
- Request inputs are ignored outside IDLE. Changes to addr or wdata after grant have no effect.
- Reset mid-BUSY or mid-RESP:
  - mf_v and ready drop immediately (asynchronously) and state returns to IDLE.
  - The in-flight store may or may not have been committed by memory.
  - No ready pulse is produced.

Test Plan:
1. Reset: reset=1 for 2 cycles with if_req=mem_req=1 -> all outputs 0 and mf_v=0 throughout; state IDLE after release.
2. Single fetch: if_req=1, if_addr=0x10, mf_stall=0, mf_data_out=0x43 -> mf_v=1 one cycle with mf_address=0x10 and mf_we=0; if_ready pulses in cycle 2 with if_rdata=0x43; if_stall=1 until then.
3. Store then load with stall:
   - Store: mem_req=1, mem_we=1, mem_addr=0, mem_wdata=67, mf_stall=1 for 3 cycles -> mf_v/mf_we/mf_data=67 held 4 cycles; mem_ready pulses once.
   - Load of addr 0 with mf_data_out=67 -> mem_rdata=67.
4. Contention/starvation, STARVE_MAX=4: if_req and mem_req held continuously (re-requesting MEM after each ready) -> grant order MEM,MEM,MEM,MEM,IF,MEM...; starve_cnt returns to 0 after the IF grant.
5. Abort: reset asserted while BUSY with mf_stall=1 -> mf_v=0 the same cycle; no ready pulse; after release, a new if_req completes normally.
6. Dropped request: mem_req deasserted one cycle into BUSY -> transaction still completes; mem_ready pulses once; the next idle grant serves a pending if_req.
